main_memory_line: RTL
=====================

# main_memory_line

Line-granular main-memory model sitting directly downstream of the cache controller (the instruction/data memory arbiter). It accepts one 128-bit line read or write at a time on the shared `read_Mem`/`write_Mem`/`Addr_Mem` bus. It holds `ready_mem` low for a fixed programmable latency, then completes the access and raises `ready_mem`. That rising edge is the completion event the arbiter keys on.

## Interface
- `LINES`, 256: number of 128-bit lines stored; power of two, at least 2.
- `LATENCY`, 5: cycles `ready_mem` stays low per access; at least 1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `read_Mem`  in  1  line read request.
- `write_Mem`  in  1  line write request; wins if asserted together with `read_Mem`.
- `Addr_Mem`  in  32  byte address.
- `Data_Mem_write`  in  128  write line.
- `Data_Mem_read`  out  128  last line read; held until the next read completes.
- `ready_mem`  out  1  high = idle or just completed; low = access in flight.

## Operation
- States:
  - IDLE: `ready_mem`=1.
  - BUSY: `ready_mem`=0, down-counter `cnt` running.
  - DONE: `ready_mem`=1 for exactly one cycle.
- Reset (`rst_n`=0, asynchronous):
  - state is IDLE, `ready_mem`=1, `Data_Mem_read`=0, `cnt`=0.
  - Storage array is not cleared.
- IDLE, with `read_Mem` or `write_Mem` high at an edge:
  - Capture the op (write if `write_Mem`, else read), the line index and the write data into hold registers.
  - Set `cnt`=LATENCY-1 and go to BUSY.
  - Inputs may change freely after acceptance.
- BUSY, `cnt`≠0: decrement `cnt`.
- BUSY, `cnt`=0: perform the access and go to DONE.
  - Read: `Data_Mem_read` ← line[idx].
  - Write: line[idx] ← held data; `Data_Mem_read` unchanged.
- DONE: requests are ignored; go to IDLE on the next edge.
  - A request still asserted in IDLE starts a new access.
  - Requesters deassert on seeing `ready_mem` rise.
- Index and width rules:
  - idx = `Addr_Mem`[4+log2(LINES)-1:4].
  - Bits [3:0] are ignored, because accesses are line-aligned.
  - Address bits above the index are ignored, so addresses alias modulo LINES×16 bytes.
- Requests arriving in BUSY are ignored, not queued; the arbiter guarantees a single outstanding access.
- Reset mid-access aborts it:
  - A pending write is not committed, because the commit happens only at the BUSY→DONE edge.
  - `Data_Mem_read` returns to 0.

## Timing
- Request sampled at edge k in IDLE:
  - `ready_mem` is low from just after edge k until edge k+LATENCY.
  - At edge k+LATENCY, `ready_mem` rises and read data is valid on `Data_Mem_read`.
  - At edge k+LATENCY+1, the state returns to IDLE.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- LATENCY=1: BUSY lasts a single cycle.
- Read of a line written by the immediately preceding access returns the new data; there is no forwarding hazard, because the write commits before DONE.
- `Data_Mem_read` changes only at a read-completion edge or on reset.

## Structure
- Package `mem_pkg`:
  - `LINE_W`=128, `OFFSET_W`=4.
  - State enum {IDLE, BUSY, DONE}.
- Sub-module `line_ram`: single-port synchronous RAM, LINES×128, with write enable and registered read.
  - The FSM drives it once, in the final BUSY cycle.
  - Its registered output feeds a `Data_Mem_read` holding register loaded on read completion.
- Top level contains the FSM, the `cnt` counter and the hold registers.

## Test plan
- Reset with `rst_n` low for 3 cycles → `ready_mem`=1, `Data_Mem_read`=0, no access started even with `read_Mem` held high during reset.
- Write line 0x0123…CDEF to `Addr_Mem`=0x40, then read 0x4C → `ready_mem` low for exactly 5 cycles on each access; read returns 0x0123…CDEF.
- Set LINES=256 and write to 0x1040 → a read of 0x0040 returns the same line (alias); a read of 0x0050 is unaffected.
- `read_Mem` and `write_Mem` both high → access is a write and `Data_Mem_read` is unchanged; toggling `Addr_Mem`/`Data_Mem_write` during BUSY does not alter the stored line.
- Pull `rst_n` low in the 3rd BUSY cycle of a write to 0x80 that holds 0xAA…AA, then read 0x80 → the old content is returned.
- Set LATENCY=1 and keep `read_Mem` held high continuously → `ready_mem` pattern 1,0,1,1,0,1,1,… with one access every 3 cycles.

Source files
------------

// File: rtl/main_memory_line_pkg.sv
// Shared widths and FSM state type for the line-granular main-memory model.
package mem_pkg;

  localparam int unsigned LINE_W   = 128;
  localparam int unsigned OFFSET_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/main_memory_line_ram.sv
// Single-port synchronous line RAM with write enable and registered read.
import mem_pkg::*;

module line_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Storage is never cleared, so reset leaves the array untouched.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // The read register only loads on a read, so it doubles as the held read line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/main_memory_line.sv
// Line-granular main memory: accepts one line access, holds ready_mem low for LATENCY cycles, then completes.
import mem_pkg::*;

module main_memory_line #(
  parameter int unsigned LINES   = 256,
  parameter int unsigned LATENCY = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_Mem,
  input  logic              write_Mem,
  input  logic [31:0]       Addr_Mem,
  input  logic [LINE_W-1:0] Data_Mem_write,
  output logic [LINE_W-1:0] Data_Mem_read,
  output logic              ready_mem
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              hold_we;
  logic [IDX_W-1:0]  hold_idx;
  logic [LINE_W-1:0] hold_data;
  logic              ram_en;
  logic              req;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{Addr_Mem[OFFSET_W-1:0], Addr_Mem[31:OFFSET_W+IDX_W]};

  assign req = read_Mem | write_Mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_we   <= 1'b0;
      hold_idx  <= '0;
      hold_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            hold_we   <= write_Mem;
            hold_idx  <= Addr_Mem[OFFSET_W +: IDX_W];
            hold_data <= Data_Mem_write;
            cnt       <= CNT_W'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ready_mem = 1'b1;
    case (state)
      IDLE: if (req) state_nxt = BUSY;
      BUSY: begin
        ready_mem = 1'b0;
        if (cnt == '0) begin
          ram_en    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The RAM read register is loaded only at a read completion, so it is the Data_Mem_read holding register.
  line_ram #(
    .DEPTH (LINES),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (hold_we),
    .addr  (hold_idx),
    .wdata (hold_data),
    .rdata (Data_Mem_read)
  );

endmodule
